// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Instruction store for the pipeline fetch stage together with a host-side
// program loader. The store holds 2**AW words of DW bits. The fetch stage reads
// it asynchronously. The host streams the program in as bytes, high byte first,
// and the loader packs each pair of bytes into one word. While a load is in
// progress the CPU is held idle. When the load completes, the CPU receives a
// one-cycle reset pulse and is then released to execute.
//
// Ports
//   clock      in   system clock, rising-edge
//   reset      in   asynchronous, active-low reset of the control registers
//   i_addr     in   fetch address (CPU pc)
//   i_datain   out  instruction at i_addr in RUN, 16'h0000 (NOP) otherwise
//   state      out  CPU run control: exec (1) in RUN after the reset pulse,
//                   idle (0) otherwise
//   cpu_rst_n  out  active-low CPU reset, low for one cycle on entry to RUN
//   ld_start   in   pulse: restart loading at address 0, clears ld_err
//   ld_valid   in   ld_byte is valid
//   ld_byte    in   program byte
//   ld_last    in   ld_byte is the final byte of the program
//   ld_ready   out  loader accepts a byte this cycle
//   ld_err     out  sticky: program overflowed the store
//   prog_len   out  words written by the most recent load (0..2**AW)
//   dbg_fsm_o  out  loader FSM state, for debug visibility
//
// Handshake: a byte transfers on a rising edge where ld_valid && ld_ready.
// ld_ready is decoded from the registered FSM state only, so it never depends
// on ld_valid. The producer may hold ld_valid high for as long as it likes;
// ld_last is only considered on a transferring edge.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_datain,
    output logic          state,
    output logic          cpu_rst_n,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_err,
    output logic [AW:0]   prog_len,
    output logic [1:0]    dbg_fsm_o
);

    localparam int DEPTH = 1 << AW;

    // CPU run-control encoding used by the pipeline
    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_EXEC = 1'b1;

    localparam logic [1:0] S_WAIT    = 2'd0;
    localparam logic [1:0] S_LOAD_HI = 2'd1;
    localparam logic [1:0] S_LOAD_LO = 2'd2;
    localparam logic [1:0] S_RUN     = 2'd3;

    logic [1:0]    fsm_q,      fsm_d;
    logic [AW-1:0] wptr_q,     wptr_d;
    logic [7:0]    hi_q,       hi_d;
    logic [AW:0]   prog_len_q, prog_len_d;
    logic          err_q,      err_d;
    // Set on the edge that enters RUN and cleared on the next edge.
    // It holds the CPU in reset and keeps it idle for that one cycle.
    logic          pulse_q,    pulse_d;

    logic [DW-1:0] mem_q [0:DEPTH-1];
    logic          mem_we;
    logic [DW-1:0] mem_wdata;

    logic          xfer;
    logic          wptr_full;
    logic [AW:0]   wptr_plus1;

    assign ld_ready   = (fsm_q == S_LOAD_HI) || (fsm_q == S_LOAD_LO);
    assign xfer       = ld_valid && ld_ready;
    assign wptr_full  = (wptr_q == {AW{1'b1}});
    assign wptr_plus1 = {1'b0, wptr_q} + {{AW{1'b0}}, 1'b1};

    always_comb begin
        fsm_d      = fsm_q;
        wptr_d     = wptr_q;
        hi_d       = hi_q;
        prog_len_d = prog_len_q;
        err_d      = err_q;
        pulse_d    = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        if (ld_start) begin
            // A restart wins over any transfer on the same edge, and it
            // drops a half-assembled word.
            fsm_d      = S_LOAD_HI;
            wptr_d     = '0;
            prog_len_d = '0;
            err_d      = 1'b0;
            hi_d       = 8'h00;
        end else if (xfer) begin
            case (fsm_q)
                S_LOAD_HI: begin
                    hi_d = ld_byte;
                    if (ld_last) begin
                        // Odd byte count: pad the final word's low byte.
                        mem_we     = 1'b1;
                        mem_wdata  = {ld_byte, 8'h00};
                        prog_len_d = wptr_plus1;
                        fsm_d      = S_RUN;
                        pulse_d    = 1'b1;
                    end else begin
                        fsm_d = S_LOAD_LO;
                    end
                end
                S_LOAD_LO: begin
                    mem_we     = 1'b1;
                    mem_wdata  = {hi_q, ld_byte};
                    prog_len_d = wptr_plus1;
                    if (ld_last) begin
                        fsm_d   = S_RUN;
                        pulse_d = 1'b1;
                    end else if (wptr_full) begin
                        // The store is full. Stop here rather than wrap, so
                        // word 0 is never overwritten.
                        err_d   = 1'b1;
                        fsm_d   = S_RUN;
                        pulse_d = 1'b1;
                    end else begin
                        wptr_d = wptr_q + {{(AW-1){1'b0}}, 1'b1};
                        fsm_d  = S_LOAD_HI;
                    end
                end
                default: begin
                    fsm_d = fsm_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q      <= S_WAIT;
            wptr_q     <= '0;
            hi_q       <= 8'h00;
            prog_len_q <= '0;
            err_q      <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            wptr_q     <= wptr_d;
            hi_q       <= hi_d;
            prog_len_q <= prog_len_d;
            err_q      <= err_d;
            pulse_q    <= pulse_d;
        end
    end

    // The store is not reset. A reset only abandons the load; the words
    // already written keep their contents.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wptr_q] <= mem_wdata;
        end
    end

    assign i_datain  = (fsm_q == S_RUN) ? mem_q[i_addr] : '0;
    assign state     = ((fsm_q == S_RUN) && !pulse_q) ? STATE_EXEC : STATE_IDLE;
    assign cpu_rst_n = !pulse_q;
    assign ld_err    = err_q;
    assign prog_len  = prog_len_q;
    assign dbg_fsm_o = fsm_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed and randomized bench for imem_loader. A word-level reference model
// packs the byte stream into words and tracks which store locations hold known
// contents. Inputs are driven 1 ns after the rising edge, and outputs are
// sampled at the same point.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = 256;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_datain;
  logic          state;
  logic          cpu_rst_n;
  logic          ld_start;
  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_err;
  logic [AW:0]   prog_len;
  logic [1:0]    dbg_fsm;

  imem_loader #(.AW(AW), .DW(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .i_addr    (i_addr),
    .i_datain  (i_datain),
    .state     (state),
    .cpu_rst_n (cpu_rst_n),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .ld_err    (ld_err),
    .prog_len  (prog_len),
    .dbg_fsm_o (dbg_fsm)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0]    load_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mm[DEPTH];
  bit            known[DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pack bytes pairwise, high byte first. A trailing odd byte becomes a word
  // only when the stream ended with ld_last. The store holds at most DEPTH
  // words, and a stream of 2*DEPTH bytes or more with no last flag overflows.
  function automatic void model_apply(input bit has_last, input int n,
                                      output int words, output bit err);
    words = 0;
    for (int i = 0; i < n && words < DEPTH; i += 2) begin
      if (i + 1 < n) begin
        mm[words] = {load_q[i], load_q[i+1]};
        known[words] = 1'b1;
        words++;
      end else if (has_last) begin
        mm[words] = {load_q[i], 8'h00};
        known[words] = 1'b1;
        words++;
      end
    end
    err = !has_last && (n >= 2 * DEPTH);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit last, output bit acc);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    acc      = ld_ready;  // ready is stable between edges
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".state"},     32'(state),     32'(0));
    check({tag, ".cpu_rst_n"}, 32'(cpu_rst_n), 32'(1));
    check({tag, ".ld_ready"},  32'(ld_ready),  32'(0));
    check({tag, ".ld_err"},    32'(ld_err),    32'(0));
    check({tag, ".prog_len"},  32'(prog_len),  32'(0));
    check({tag, ".fsm_wait"},  32'(dbg_fsm),   32'(0));
    for (int k = 0; k < 4; k++) begin
      i_addr = 8'($urandom_range(0, DEPTH - 1));
      #1;
      check({tag, ".i_datain"}, 32'(i_datain), 32'(0));
    end
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      if (known[a]) exp_q.push_back(mm[a]);
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (known[a]) begin
        i_addr = 8'(a);
        #1;
        check($sformatf("%s.mem[%0d]", tag, a), 32'(i_datain), 32'(exp_q.pop_front()));
      end
    end
  endtask

  // Sends load_q. gap: 0 back-to-back, 1 idle cycle between bytes, 2 random
  // idle cycles. RUN is entered at the last byte, or after 2*DEPTH bytes when
  // there is no last flag; any bytes after that must be refused.
  task automatic send_load(input string tag, input int gap, input bit has_last, input bit do_start);
    int n;
    int end_idx;
    int g;
    int words;
    bit err;
    bit acc;
    n = load_q.size();
    end_idx = has_last ? n - 1 : 2 * DEPTH - 1;
    if (do_start) pulse_start();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && i <= end_idx) begin
        g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (g) step();
      end
      drive_byte(load_q[i], has_last && (i == n - 1), acc);
      check($sformatf("%s.accept[%0d]", tag, i), 32'(acc), 32'(i <= end_idx));
      if (i == end_idx) begin
        check({tag, ".pulse_rst_n"}, 32'(cpu_rst_n), 32'(0));
        check({tag, ".pulse_state"}, 32'(state),     32'(0));
      end
      if (i == end_idx + 1) begin
        check({tag, ".run_rst_n"}, 32'(cpu_rst_n), 32'(1));
        check({tag, ".run_state"}, 32'(state),     32'(1));
      end
    end
    if (end_idx == n - 1) begin
      step();
      check({tag, ".run_rst_n"}, 32'(cpu_rst_n), 32'(1));
      check({tag, ".run_state"}, 32'(state),     32'(1));
    end
    model_apply(has_last, n, words, err);
    check({tag, ".prog_len"}, 32'(prog_len), 32'(words));
    check({tag, ".ld_err"},   32'(ld_err),   32'(err));
    check_mem(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    bit e;
    bit acc;
    reset    = 1'b0;
    i_addr   = '0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_byte  = 8'h00;
    ld_last  = 1'b0;
    for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;

    repeat (3) step();
    check_reset_vals("reset0");
    reset = 1'b1;
    step();
    check_reset_vals("after_release");

    // Random preload gives the store known prior contents.
    load_q.delete();
    for (int i = 0; i < 16; i++) load_q.push_back(8'($urandom_range(0, 255)));
    send_load("preload", 2, 1'b1, 1'b1);

    // Three words back-to-back.
    load_q = '{8'h48, 8'h01, 8'h12, 8'h34, 8'hA5, 8'hA5};
    send_load("b2b", 0, 1'b1, 1'b1);
    i_addr = 8'd1;
    #1;
    check("b2b.addr1", 32'(i_datain), 32'(16'h1234));
    i_addr = 8'd3;
    #1;
    check("b2b.addr3_prior", 32'(i_datain), 32'(mm[3]));

    // Same load with ld_valid toggling.
    send_load("toggle", 1, 1'b1, 1'b1);

    // Odd byte count.
    load_q = '{8'hAB, 8'hCD, 8'hEF};
    send_load("odd", 0, 1'b1, 1'b1);
    i_addr = 8'd0;
    #1;
    check("odd.mem0", 32'(i_datain), 32'(16'hABCD));
    i_addr = 8'd1;
    #1;
    check("odd.mem1", 32'(i_datain), 32'(16'hEF00));

    // Overflow: 514 bytes with no last flag.
    load_q.delete();
    for (int i = 0; i < 514; i++) load_q.push_back(8'($urandom_range(0, 255)));
    send_load("ovf", 0, 1'b0, 1'b1);
    i_addr = 8'd0;
    #1;
    check("ovf.mem0_kept", 32'(i_datain), 32'({load_q[0], load_q[1]}));

    // Restart while in LOAD_LO. The second restart coincides with a byte.
    pulse_start();
    check("restart.err_clr", 32'(ld_err),   32'(0));
    check("restart.ready",   32'(ld_ready), 32'(1));
    check("restart.state",   32'(state),    32'(0));
    drive_byte(8'h11, 1'b0, acc);
    check("restart.hi_acc", 32'(acc), 32'(1));
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'h99;
    ld_last  = 1'b1;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("restart.prio_state",  32'(state),     32'(0));
    check("restart.prio_rst_n",  32'(cpu_rst_n), 32'(1));
    check("restart.prio_len",    32'(prog_len),  32'(0));
    load_q = '{8'h22, 8'h33};
    send_load("restart", 0, 1'b1, 1'b0);
    i_addr = 8'd0;
    #1;
    check("restart.mem0", 32'(i_datain), 32'(16'h2233));

    // ld_start from RUN drops the CPU back to idle.
    pulse_start();
    check("run_restart.state", 32'(state),    32'(0));
    check("run_restart.ready", 32'(ld_ready), 32'(1));

    // Reset mid-load: the words already written stay in memory.
    load_q.delete();
    for (int i = 0; i < 5; i++) load_q.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 5; i++) begin
      drive_byte(load_q[i], 1'b0, acc);
      check($sformatf("abort.accept[%0d]", i), 32'(acc), 32'(1));
    end
    model_apply(1'b0, 5, w, e);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("reset_midload");
    step();
    reset = 1'b1;
    step();
    check_reset_vals("after_midload");
    load_q = '{8'($urandom_range(0, 255))};
    send_load("reload1", 0, 1'b1, 1'b1);

    // Reset while in RUN.
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("reset_run");
    step();
    reset = 1'b1;
    step();
    check_reset_vals("after_run_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
